// File: rtl/dsc_mul_ctrl_pkg.sv
// Shared definitions for the stochastic (DSC) multiplier: operand sizing,
// result width and the controller state encoding. Also imported by dsc_mul.
package dsc_mul_ctrl_pkg;

  localparam int DSC_SNG_WIDTH  = 10;
  localparam int DSC_NUM_INPUTS = 4;
  localparam int DSC_ZW         = DSC_SNG_WIDTH * DSC_NUM_INPUTS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } dsc_state_e;

endpackage

// File: rtl/dsc_mul_ctrl_sat_counter.sv
// Saturating up-counter used to count RUN cycles.
// Ports:
//   clk, rst  clock / async active-high reset
//   clr_i     synchronous clear (wins over en_i)
//   en_i      count enable
//   cnt_o     current count
//   nxt_o     count after one more enabled cycle (saturated)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o
);

  logic [W-1:0] cnt_q;

  // Hold at all-ones rather than wrapping back to zero.
  assign nxt_o = (&cnt_q) ? cnt_q : cnt_q + W'(1);
  assign cnt_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= nxt_o;
  end

endmodule

// File: rtl/dsc_mul_ctrl.sv
// Controller for the stochastic multiplier core: accepts an operand set,
// clears and runs the core until it signals overflow or a cycle budget
// expires, captures the core count and presents it until consumed.
// Ports:
//   clk, rst                     clock / async active-high reset
//   in_valid/in_ready            operand handshake, in_a..in_d operands
//   out_valid/out_ready          result handshake
//   out_z, out_cycles, out_timeout  captured count, RUN cycles, timeout flag
//   core_a..core_d, core_rst, core_en  drive to the multiplier core
//   core_z, core_ov              core count and early-shutoff indication
module dsc_mul_ctrl
  import dsc_mul_ctrl_pkg::*;
#(
  parameter  int              SNG_WIDTH  = DSC_SNG_WIDTH,
  parameter  int              NUM_INPUTS = DSC_NUM_INPUTS,
  localparam int              ZW         = NUM_INPUTS * SNG_WIDTH,
  parameter  longint unsigned TIMEOUT    = 64'd1 << ZW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] in_a,
  input  logic [SNG_WIDTH-1:0] in_b,
  input  logic [SNG_WIDTH-1:0] in_c,
  input  logic [SNG_WIDTH-1:0] in_d,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ZW-1:0]        out_z,
  output logic [ZW:0]          out_cycles,
  output logic                 out_timeout,
  output logic [SNG_WIDTH-1:0] core_a,
  output logic [SNG_WIDTH-1:0] core_b,
  output logic [SNG_WIDTH-1:0] core_c,
  output logic [SNG_WIDTH-1:0] core_d,
  output logic                 core_rst,
  output logic                 core_en,
  input  logic [ZW-1:0]        core_z,
  input  logic                 core_ov
);

  localparam logic [ZW:0] TMO = (ZW+1)'(TIMEOUT);

  dsc_state_e           state_q, state_d;
  logic [SNG_WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic [ZW-1:0]        z_q;
  logic [ZW:0]          cyc_q;
  logic                 tmo_q;

  logic [ZW:0] cnt, cnt_nxt;
  logic        cnt_clr, cnt_en;
  logic        any_zero, ov_hit, tmo_hit;

  assign cnt_clr = (state_q == S_CLEAR);
  assign cnt_en  = (state_q == S_RUN);

  sat_counter #(.W(ZW+1)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .nxt_o (cnt_nxt)
  );

  // A zero operand forces a zero product, so the core is skipped entirely.
  assign any_zero = (in_a == '0) || (in_b == '0) || (in_c == '0) || (in_d == '0);
  // cnt==0 marks the first RUN cycle, where core_ov is start-up noise.
  assign ov_hit   = core_ov && (cnt != '0);
  // cnt_nxt is the RUN-cycle count including the current cycle.
  assign tmo_hit  = (cnt_nxt >= TMO);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = any_zero ? S_DONE : S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (ov_hit || tmo_hit) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else if (state_q == S_IDLE && in_valid) begin
      a_q <= in_a;
      b_q <= in_b;
      c_q <= in_c;
      d_q <= in_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q   <= '0;
      cyc_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid && any_zero) begin
          z_q   <= '0;
          cyc_q <= '0;
          tmo_q <= 1'b0;
        end
        // Overflow wins a tie with the budget.
        S_RUN:   if (ov_hit || tmo_hit) tmo_q <= !ov_hit;
        // Core stopped last edge, so core_z now holds the final increment.
        S_DRAIN: begin
          z_q   <= core_z;
          cyc_q <= cnt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_z       = z_q;
  assign out_cycles  = cyc_q;
  assign out_timeout = tmo_q;
  assign core_a      = a_q;
  assign core_b      = b_q;
  assign core_c      = c_q;
  assign core_d      = d_q;
  // Core is held cleared for as long as reset is asserted.
  assign core_rst    = rst || (state_q == S_CLEAR);
  assign core_en     = (state_q == S_RUN);

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// Self-checking bench for dsc_mul_ctrl with a behavioural core stub.
module tb_dsc_mul_ctrl;

  localparam int SW = 10;
  localparam int ZW = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [SW-1:0] in_a, in_b, in_c, in_d;
  logic          out_valid, out_ready;
  logic [ZW-1:0] out_z;
  logic [ZW:0]   out_cycles;
  logic          out_timeout;
  logic [SW-1:0] core_a, core_b, core_c, core_d;
  logic          core_rst, core_en;
  logic [ZW-1:0] core_z;
  logic          core_ov;

  always #5 clk = ~clk;

  dsc_mul_ctrl #(.TIMEOUT(64'd16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_cycles(out_cycles), .out_timeout(out_timeout),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
    .core_rst(core_rst), .core_en(core_en),
    .core_z(core_z), .core_ov(core_ov)
  );

  // Core stub: loads stub_base on clear, counts up while enabled, and
  // raises core_ov in RUN cycle ov_at (0 = never).
  logic [ZW-1:0] stub_base, stub_z;
  int            ov_at, rc;

  always @(posedge clk) begin
    if (core_rst) begin
      stub_z <= stub_base;
      rc     <= 0;
    end else if (core_en) begin
      stub_z <= stub_z + 1;
      rc     <= rc + 1;
    end
  end
  assign core_z  = stub_z;
  assign core_ov = core_en && (ov_at != 0) && (rc + 1 == ov_at);

  typedef struct packed {
    logic [ZW-1:0] z;
    logic [ZW:0]   cyc;
    logic          tmo;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_seen;
  exp_t mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per result presentation.
  initial begin
    mon_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !mon_seen) begin
        mon_seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: out_z=%0d with empty scoreboard", out_z);
        end else begin
          mon_e = sb.pop_front();
          chk("out_z", 64'(out_z), 64'(mon_e.z));
          chk("out_cycles", 64'(out_cycles), 64'(mon_e.cyc));
          chk("out_timeout", 64'(out_timeout), 64'(mon_e.tmo));
        end
      end else if (!out_valid) begin
        mon_seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [SW-1:0] a, b, c, d);
    in_a = a; in_b = b; in_c = c; in_d = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("core_operands", 64'({core_a, core_b, core_c, core_d}), 64'({a, b, c, d}));
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int n;
    n = 0;
    while (!out_valid && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(out_valid), 64'd1);
  endtask

  task automatic run_op(input logic [SW-1:0] a, b, c, d,
                        input logic [ZW-1:0] base, input int ov);
    stub_base = base;
    ov_at     = ov;
    issue(a, b, c, d);
    @(negedge clk);
    chk("clear_pulse", 64'({core_rst, core_en}), 64'd2);
    wait_valid("op_done", 40);
    @(posedge clk); #1;
    chk("back_to_idle", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    stub_base = '0; ov_at = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_core_rst", 64'(core_rst), 64'd1);
    chk("rst_core_en", 64'(core_en), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_z", 64'(out_z), 64'd0);
    chk("rst_out_cycles", 64'(out_cycles), 64'd0);
    chk("rst_out_timeout", 64'(out_timeout), 64'd0);
    chk("rst_core_ops", 64'({core_a, core_b, core_c, core_d}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_core_rst", 64'(core_rst), 64'd0);

    // Overflow in RUN cycle 5, core at 37 then 38 after the final edge
    sb.push_back('{z: 40'd38, cyc: 41'd5, tmo: 1'b0});
    run_op(10'd512, 10'd512, 10'd512, 10'd512, 40'd33, 5);

    // Zero operand: straight to DONE, core untouched
    sb.push_back('{z: 40'd0, cyc: 41'd0, tmo: 1'b0});
    stub_base = 40'd999; ov_at = 0;
    issue(10'd0, 10'd700, 10'd700, 10'd700);
    chk("zero_core_en", 64'(core_en), 64'd0);
    chk("zero_core_rst", 64'(core_rst), 64'd0);
    wait_valid("zero_done", 2);
    chk("zero_core_en2", 64'(core_en), 64'd0);
    @(posedge clk); #1;
    chk("zero_idle", 64'(in_ready), 64'd1);

    // First-cycle overflow masked, ends on the 16-cycle budget
    sb.push_back('{z: 40'd116, cyc: 41'd16, tmo: 1'b1});
    run_op(10'd300, 10'd400, 10'd500, 10'd600, 40'd100, 1);

    // Overflow coincides with the budget: reported as overflow
    sb.push_back('{z: 40'd66, cyc: 41'd16, tmo: 1'b0});
    run_op(10'd1, 10'd1, 10'd1, 10'd1, 40'd50, 16);

    // Backpressure in DONE
    sb.push_back('{z: 40'd23, cyc: 41'd3, tmo: 1'b0});
    out_ready = 1'b0;
    stub_base = 40'd20; ov_at = 3;
    issue(10'd10, 10'd20, 10'd30, 10'd40);
    @(negedge clk);
    chk("bp_clear_pulse", 64'({core_rst, core_en}), 64'd2);
    wait_valid("bp_done", 40);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a = 10'd5; in_b = 10'd6; in_c = 10'd7; in_d = 10'd8;
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_z", 64'(out_z), 64'd23);
      chk("bp_out_cycles", 64'(out_cycles), 64'd3);
      chk("bp_core_a", 64'(core_a), 64'd10);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Reset in RUN cycle 3, then a clean operation
    stub_base = '0; ov_at = 0;
    issue(10'd100, 10'd100, 10'd100, 10'd100);
    @(negedge clk);
    chk("abort_clear_pulse", 64'({core_rst, core_en}), 64'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_run3_en", 64'(core_en), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_core_en", 64'(core_en), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_core_rst", 64'(core_rst), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_core_en2", 64'(core_en), 64'd0);

    sb.push_back('{z: 40'd11, cyc: 41'd4, tmo: 1'b0});
    run_op(10'd9, 10'd9, 10'd9, 10'd9, 40'd7, 4);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
